mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 100 ++++++++++
 tb/tb_mem_access.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage issuing one data-memory request per load/store.
// Optional MEM_ALIGN_CHECK_EN flags misaligned word accesses instead of issuing them.
package mem_access_pkg;
  typedef struct packed {
    logic        mem_to_reg;
    logic        mem_write;
    logic        reg_write;
    logic        reg_dst;
    logic [31:0] alu_result;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] instruction;
  } e_m_reg_t;
  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  wsel;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        misalign;
  } m_w_reg_t;
endpackage

module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  e_m_reg_t    e_m_reg,
  input  logic [31:0] store_data,
  output logic        in_ready,
  output logic        dreq_valid,
  output logic        dreq_write,
  output logic [31:0] dreq_addr,
  output logic [31:0] dreq_wdata,
  output logic [3:0]  dreq_strobe,
  input  logic        dreq_ready,
  input  logic        dresp_valid,
  input  logic [31:0] dresp_data,
  output logic        out_valid,
  output m_w_reg_t    m_w_reg
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} st_t;
  st_t         st_q, st_d;
  m_w_reg_t    m_w_q, m_w_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        cap, mem, mis;
  assign in_ready = st_q == IDLE || st_q == DONE;
  assign cap = in_valid && in_ready;
  assign mem = e_m_reg.mem_to_reg || e_m_reg.mem_write;
`ifdef MEM_ALIGN_CHECK_EN
  assign mis = mem && |e_m_reg.alu_result[1:0];
`else
  assign mis = 1'b0;
`endif
  // The captured alu_result doubles as the request address.
  assign dreq_valid = st_q == REQ;
  assign dreq_write = dreq_valid && wr_q;
  assign dreq_addr = dreq_valid ? m_w_q.alu_result : '0;
  assign dreq_wdata = dreq_valid ? wdata_q : '0;
  assign dreq_strobe = dreq_write ? 4'hF : 4'h0;
  assign out_valid = st_q == DONE;
  assign m_w_reg = m_w_q;
  always_comb begin
    st_d = st_q;
    m_w_d = m_w_q;
    wdata_d = wdata_q;
    wr_d = wr_q;
    if (cap) begin
      st_d = (mem && !mis) ? REQ : DONE;
      m_w_d = '{reg_write: e_m_reg.reg_write && !mis, mem_to_reg: e_m_reg.mem_to_reg,
                wsel: e_m_reg.reg_dst ? e_m_reg.rd : e_m_reg.rt, alu_result: e_m_reg.alu_result,
                read_data: 32'h0, pc: e_m_reg.pc, instruction: e_m_reg.instruction, misalign: mis};
      wdata_d = store_data;
      wr_d = e_m_reg.mem_write;
    end else if (st_q == DONE) st_d = IDLE;
    else if (st_q == REQ && dreq_ready) st_d = RESP;
    else if (st_q == RESP && dresp_valid) begin
      st_d = DONE;
      m_w_d.read_data = m_w_q.mem_to_reg ? dresp_data : 32'h0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_q <= IDLE;
      m_w_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
    end else begin
      st_q <= st_d;
      m_w_q <= m_w_d;
      wdata_q <= wdata_d;
      wr_q <= wr_d;
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized self-checking bench for mem_access with a rule-based expected-output model.
module tb_mem_access;
  import mem_access_pkg::*;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  e_m_reg_t    e_m_reg = '0;
  logic [31:0] store_data = '0;
  logic        in_ready;
  logic        dreq_valid, dreq_write;
  logic [31:0] dreq_addr, dreq_wdata;
  logic [3:0]  dreq_strobe;
  logic        dreq_ready = 1'b0;
  logic        dresp_valid = 1'b0;
  logic [31:0] dresp_data = '0;
  logic        out_valid;
  m_w_reg_t    m_w_reg;
  int nvec = 0;
  int nerr = 0;

  mem_access dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .e_m_reg(e_m_reg), .store_data(store_data),
    .in_ready(in_ready), .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_wdata(dreq_wdata), .dreq_strobe(dreq_strobe), .dreq_ready(dreq_ready),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data), .out_valid(out_valid), .m_w_reg(m_w_reg)
  );

  always #5 clk = ~clk;

  function automatic e_m_reg_t mk(input bit ld, input bit st, input bit rw, input bit dst,
                                  input logic [31:0] addr, input logic [4:0] rt, input logic [4:0] rd);
    e_m_reg_t e;
    e.mem_to_reg = ld;
    e.mem_write = st;
    e.reg_write = rw;
    e.reg_dst = dst;
    e.alu_result = addr;
    e.rt = rt;
    e.rd = rd;
    e.pc = $urandom;
    e.instruction = $urandom;
    return e;
  endfunction

  task automatic run_op(input e_m_reg_t e, input logic [31:0] sd, input logic [31:0] rdata,
                        input int rdy_dly, input int rsp_dly, input bit b2b, input string nm);
    bit mem, mis;
    m_w_reg_t exp;
    logic [71:0] got, want;
    mem = e.mem_to_reg || e.mem_write;
    mis = ALIGN && mem && (e.alu_result[1:0] != 2'b00);
    exp.reg_write = e.reg_write && !mis;
    exp.mem_to_reg = e.mem_to_reg;
    exp.wsel = e.reg_dst ? e.rd : e.rt;
    exp.alu_result = e.alu_result;
    exp.read_data = (e.mem_to_reg && !mis) ? rdata : 32'h0;
    exp.pc = e.pc;
    exp.instruction = e.instruction;
    exp.misalign = mis;
    if (!b2b) begin
      @(negedge clk);
      nvec++;
      if (out_valid !== 1'b0) begin
        nerr++;
        $display("FAIL %s idle_out_valid: got %b want 0", nm, out_valid);
      end
    end
    e_m_reg = e;
    store_data = sd;
    in_valid = 1'b1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL %s in_ready_accept: got %b want 1", nm, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (mem && !mis) begin
      for (int i = 0; i <= rdy_dly; i++) begin
        got = {dreq_valid, dreq_write, dreq_addr, dreq_wdata, dreq_strobe, in_ready, out_valid};
        want = {1'b1, e.mem_write, e.alu_result, sd, e.mem_write ? 4'hF : 4'h0, 1'b0, 1'b0};
        nvec++;
        if (got !== want) begin
          nerr++;
          $display("FAIL %s req_cycle%0d: got %h want %h", nm, i, got, want);
        end
        dreq_ready = (i == rdy_dly);
        dresp_valid = 1'($urandom_range(0, 1));
        dresp_data = $urandom;
        @(negedge clk);
      end
      dreq_ready = 1'b0;
      for (int j = 0; j <= rsp_dly; j++) begin
        nvec++;
        if ({dreq_valid, in_ready, out_valid} !== 3'b000) begin
          nerr++;
          $display("FAIL %s resp_cycle%0d: got dv/ir/ov %b want 000", nm, j, {dreq_valid, in_ready, out_valid});
        end
        dresp_valid = (j == rsp_dly);
        dresp_data = (j == rsp_dly) ? rdata : $urandom;
        @(negedge clk);
      end
      dresp_valid = 1'b0;
    end
    nvec++;
    if ({out_valid, dreq_valid, in_ready} !== 3'b101) begin
      nerr++;
      $display("FAIL %s done_flags: got ov/dv/ir %b want 101", nm, {out_valid, dreq_valid, in_ready});
    end
    nvec++;
    if (m_w_reg !== exp) begin
      nerr++;
      $display("FAIL %s m_w_reg: got %h want %h", nm, m_w_reg, exp);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    nvec++;
    if ({out_valid, dreq_valid, dreq_write, dreq_addr, dreq_wdata, dreq_strobe, in_ready} !== {71'h0, 1'b1}) begin
      nerr++;
      $display("FAIL reset_outputs: got ov=%b dv=%b ir=%b addr=%h", out_valid, dreq_valid, in_ready, dreq_addr);
    end
    nvec++;
    if (m_w_reg !== '0) begin
      nerr++;
      $display("FAIL reset_m_w_reg: got %h want 0", m_w_reg);
    end
  endtask

  task automatic test_directed;
    run_op(mk(0, 0, 1, 1, 32'h10, 5'd3, 5'd5), $urandom, 32'h0, 0, 0, 0, "addi");
    run_op(mk(1, 0, 1, 0, 32'h100, 5'd7, 5'd9), $urandom, 32'hDEAD_BEEF, 3, 1, 0, "lw");
    run_op(mk(0, 1, 0, 0, 32'h200, 5'd4, 5'd0), 32'h1234_5678, $urandom, 1, 2, 0, "sw");
  endtask

  task automatic test_back_to_back;
    run_op(mk(1, 0, 1, 0, 32'h40, 5'd2, 5'd1), $urandom, $urandom, 0, 0, 0, "b2b_lw");
    run_op(mk(0, 0, 1, 1, 32'h77, 5'd1, 5'd6), $urandom, 32'h0, 0, 0, 1, "b2b_addi");
    run_op(mk(0, 1, 0, 0, 32'h80, 5'd8, 5'd0), $urandom, $urandom, 0, 0, 1, "b2b_sw");
  endtask

  task automatic test_misalign;
    run_op(mk(1, 0, 1, 0, 32'h102, 5'd10, 5'd11), $urandom, 32'hCAFE_F00D, 0, 0, 0, "misalign_lw");
    run_op(mk(0, 1, 0, 0, 32'h203, 5'd12, 5'd0), $urandom, $urandom, 1, 0, 0, "misalign_sw");
  endtask

  task automatic test_reset_in_resp;
    @(negedge clk);
    e_m_reg = mk(1, 0, 1, 0, 32'h300, 5'd3, 5'd0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    dreq_ready = 1'b1;
    @(negedge clk);
    dreq_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    nvec++;
    if ({out_valid, dreq_valid, dreq_addr, dreq_wdata, dreq_strobe, m_w_reg} !== '0) begin
      nerr++;
      $display("FAIL rst_resp_async: got ov=%b dv=%b m_w=%h", out_valid, dreq_valid, m_w_reg);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dresp_valid = 1'b1;
      dresp_data = $urandom;
      @(negedge clk);
      nvec++;
      if ({out_valid, dreq_valid, in_ready} !== 3'b001) begin
        nerr++;
        $display("FAIL rst_resp_stray%0d: got ov/dv/ir %b want 001", k, {out_valid, dreq_valid, in_ready});
      end
    end
    dresp_valid = 1'b0;
  endtask

  task automatic test_random;
    e_m_reg_t e;
    int kind;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      e = mk(kind == 1, kind == 2, 1'($urandom), 1'($urandom),
             {$urandom_range(0, 255), 2'($urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0)},
             5'($urandom), 5'($urandom));
      run_op(e, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             (n > 0) && ($urandom_range(0, 1) == 1), "random");
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_misalign;
    test_reset_in_resp;
    test_random;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
